// File: rtl/mem_stage_split_pkg.sv
// Shared MEM-stage bus layouts, widths and per-instruction wait states.
package mem_stage_split_pkg;

    localparam int ES_TO_MS_BUS_WD   = 93;
    localparam int MS_TO_WS_BUS_WD   = 87;
    localparam int MS_FWD_BLK_BUS_WD = 42;

    localparam logic [0:0] DONE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic lwr;
        logic lwl;
        logic lw;
        logic lhu;
        logic lh;
        logic lbu;
        logic lb;
    } load_op_t;

    // Bit 92 is mem_req; everything below keeps the legacy EX->MS ordering.
    typedef struct packed {
        logic        mem_req;
        logic [3:0]  cp0_idx;
        logic [4:0]  excode;
        logic        bd;
        logic        ex;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        load_op_t    load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [3:0]  cp0_idx;
        logic [4:0]  excode;
        logic        bd;
        logic        ex;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        logic [3:0]  strb;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_split_load_align.sv
// Load data extraction and per-byte register write strobes.
// Latency: combinational.
// Backpressure: none.
module mem_stage_split_load_align
    import mem_stage_split_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_word,
    input  load_op_t    i_load_op,
    input  logic        i_gr_we,
    output logic [31:0] o_result,
    output logic [3:0]  o_strb
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        o_strb   = {4{i_gr_we}};
        if (i_load_op.lb) begin
            o_result = {{24{w_byte[7]}}, w_byte};
        end else if (i_load_op.lbu) begin
            o_result = {24'd0, w_byte};
        end else if (i_load_op.lh) begin
            o_result = {{16{w_half[15]}}, w_half};
        end else if (i_load_op.lhu) begin
            o_result = {16'd0, w_half};
        end else if (i_load_op.lwl) begin
            // Unaligned-left fills the upper bytes of the destination register.
            case (i_addr)
                2'd0:    begin o_result = {i_word[7:0],  24'd0}; o_strb = 4'b1000; end
                2'd1:    begin o_result = {i_word[15:0], 16'd0}; o_strb = 4'b1100; end
                2'd2:    begin o_result = {i_word[23:0], 8'd0};  o_strb = 4'b1110; end
                default: begin o_result = i_word;                o_strb = 4'b1111; end
            endcase
            o_strb = o_strb & {4{i_gr_we}};
        end else if (i_load_op.lwr) begin
            case (i_addr)
                2'd0:    begin o_result = i_word;                 o_strb = 4'b1111; end
                2'd1:    begin o_result = {8'd0,  i_word[31:8]};  o_strb = 4'b0111; end
                2'd2:    begin o_result = {16'd0, i_word[31:16]}; o_strb = 4'b0011; end
                default: begin o_result = {24'd0, i_word[31:24]}; o_strb = 4'b0001; end
            endcase
            o_strb = o_strb & {4{i_gr_we}};
        end
    end

endmodule

// File: rtl/mem_stage_split.sv
// MEM stage for a split-transaction data bus: waits for data_ok, buffers it, aligns loads.
// Latency: 1 cycle without a request, 1+N cycles with an N-cycle data_ok delay.
// Backpressure: holds the instruction and buffered data while ws_allowin is low.
module mem_stage_split
    import mem_stage_split_pkg::*;
#(
    parameter int DATA_WD     = 32,
    parameter int ES_TO_MS_WD = ES_TO_MS_BUS_WD,
    parameter int MS_TO_WS_WD = MS_TO_WS_BUS_WD,
    parameter int MAX_CANCEL  = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ws_allowin,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0]       es_to_ms_bus,
    input  logic                         es_cancel_req,
    output logic                         ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0]       ms_to_ws_bus,
    input  logic                         data_sram_data_ok,
    input  logic [DATA_WD-1:0]           data_sram_rdata,
    output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus,
    output logic                         ms_inst_mfc0_o,
    output logic                         ms_ex_o,
    input  logic                         ws_ex,
    input  logic                         eret_flush
);

    localparam int CNT_WD = (MAX_CANCEL > 0) ? $clog2(MAX_CANCEL + 1) : 1;
    localparam logic [CNT_WD-1:0] MAX_CNT = CNT_WD'(MAX_CANCEL);
    localparam logic [CNT_WD+1:0] MAX_SUM = (CNT_WD + 2)'(MAX_CANCEL);

    generate
        if (DATA_WD != 32) begin : g_bad_data_wd
            $error("mem_stage_split: DATA_WD must be 32");
        end
        if (ES_TO_MS_WD != ES_TO_MS_BUS_WD || MS_TO_WS_WD != MS_TO_WS_BUS_WD) begin : g_bad_bus_wd
            $error("mem_stage_split: bus widths do not match the package layout");
        end
    endgenerate

    logic                r_ms_valid;
    logic [0:0]          r_state;
    logic                r_buf_valid;
    logic [DATA_WD-1:0]  r_buf_data;
    logic [CNT_WD-1:0]   r_cancel_cnt;
    es_to_ms_t           r_es;

    es_to_ms_t           w_es_in;
    ms_to_ws_t           w_ws_out;
    logic                w_flush;
    logic                w_cancel_hit;
    logic                w_data_hit;
    logic                w_ready_go;
    logic                w_load_in;
    logic                w_flush_wait;
    logic [1:0]          w_cnt_inc;
    logic [CNT_WD+1:0]   w_cnt_sum;
    logic [CNT_WD-1:0]   w_cnt_next;
    logic [DATA_WD-1:0]  w_word;
    logic [6:0]          w_load_op;
    logic                w_is_load;
    logic [31:0]         w_align_result;
    logic [3:0]          w_align_strb;
    logic [3:0]          w_strb;
    logic [31:0]         w_result;
    logic                w_data_pending;

    assign w_es_in = es_to_ms_bus;
    assign w_flush = ws_ex | eret_flush;

    // Responses owed to flushed instructions are drained before anything else.
    assign w_cancel_hit = data_sram_data_ok & (r_cancel_cnt != '0);
    assign w_data_hit   = data_sram_data_ok & ~w_cancel_hit & r_ms_valid & (r_state == WAIT);
    assign w_ready_go   = (r_state == DONE) | w_data_hit;

    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~w_flush;
    assign w_load_in      = es_to_ms_valid & ms_allowin;

    assign w_flush_wait = w_flush & r_ms_valid & (r_state == WAIT) & ~w_data_hit;
    assign w_cnt_inc    = {1'b0, w_flush_wait} + {1'b0, es_cancel_req};
    assign w_cnt_sum    = {2'b00, r_cancel_cnt} + {{CNT_WD{1'b0}}, w_cnt_inc}
                        - {{(CNT_WD + 1){1'b0}}, w_cancel_hit};
    assign w_cnt_next   = (w_cnt_sum > MAX_SUM) ? MAX_CNT : w_cnt_sum[CNT_WD-1:0];

    assign w_word = r_buf_valid ? r_buf_data : data_sram_rdata;

    mem_stage_split_load_align u_load_align (
        .i_addr    (r_es.alu_result[1:0]),
        .i_word    (w_word),
        .i_load_op (r_es.load_op),
        .i_gr_we   (r_es.gr_we),
        .o_result  (w_align_result),
        .o_strb    (w_align_strb)
    );

    assign w_load_op      = r_es.load_op;
    assign w_is_load      = |w_load_op;
    assign w_strb         = (w_is_load & r_es.ex) ? 4'b0000 : w_align_strb;
    assign w_result       = r_es.res_from_mem ? w_align_result : r_es.alu_result;
    assign w_data_pending = r_ms_valid & r_es.res_from_mem & ~w_ready_go;

    always_comb begin
        w_ws_out         = '0;
        w_ws_out.cp0_idx = r_es.cp0_idx;
        w_ws_out.excode  = r_es.excode;
        w_ws_out.bd      = r_es.bd;
        w_ws_out.ex      = r_es.ex;
        w_ws_out.eret    = r_es.eret;
        w_ws_out.mtc0    = r_es.mtc0;
        w_ws_out.mfc0    = r_es.mfc0;
        w_ws_out.strb    = w_strb;
        w_ws_out.dest    = r_es.dest;
        w_ws_out.result  = w_result;
        w_ws_out.pc      = r_es.pc;
    end

    assign ms_to_ws_bus   = w_ws_out;
    assign ms_fwd_blk_bus = {w_data_pending, {4{r_ms_valid}} & w_strb, r_es.dest, w_result};
    assign ms_ex_o        = r_ms_valid & r_es.ex;
    assign ms_inst_mfc0_o = r_ms_valid & r_es.mfc0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid   <= 1'b0;
            r_state      <= DONE;
            r_buf_valid  <= 1'b0;
            r_buf_data   <= '0;
            r_cancel_cnt <= '0;
            r_es         <= '0;
        end else begin
            r_cancel_cnt <= w_cnt_next;

            if (w_flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end

            if (w_load_in) begin
                r_es        <= w_es_in;
                r_buf_valid <= 1'b0;
            end else if (w_data_hit) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= data_sram_rdata;
            end

            if (w_flush) begin
                r_state <= DONE;
            end else if (w_load_in) begin
                r_state <= w_es_in.mem_req ? WAIT : DONE;
            end else if (w_data_hit) begin
                r_state <= DONE;
            end
        end
    end

    a_cancel_in_range: assert property (@(posedge clk) disable iff (!resetn)
        w_cnt_sum <= MAX_SUM);

    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        data_sram_data_ok |-> ((r_cancel_cnt != '0) || (r_ms_valid && r_state == WAIT)));

endmodule

// File: tb/tb_mem_stage_split.sv
// Directed bench for mem_stage_split: load alignment, stalls, flush cancellation, async reset.
module tb_mem_stage_split;

    localparam logic [6:0] OP_NONE = 7'h00;
    localparam logic [6:0] OP_LB   = 7'h01;
    localparam logic [6:0] OP_LBU  = 7'h02;
    localparam logic [6:0] OP_LW   = 7'h10;
    localparam logic [6:0] OP_LWL  = 7'h20;
    localparam logic [6:0] OP_LWR  = 7'h40;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [92:0] es_to_ms_bus;
    logic        es_cancel_req;
    logic        ms_to_ws_valid;
    logic [86:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [41:0] ms_fwd_blk_bus;
    logic        ms_inst_mfc0_o;
    logic        ms_ex_o;
    logic        ws_ex;
    logic        eret_flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_split dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_cancel_req     (es_cancel_req),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_blk_bus    (ms_fwd_blk_bus),
        .ms_inst_mfc0_o    (ms_inst_mfc0_o),
        .ms_ex_o           (ms_ex_o),
        .ws_ex             (ws_ex),
        .eret_flush        (eret_flush)
    );

    // EX->MS payload: pc[31:0] alu[63:32] dest[68:64] we[69] rfm[70] op[77:71] mfc0[78] ex[81] req[92]
    function automatic logic [92:0] mk(input logic req, input logic rfm, input logic [6:0] op,
                                       input logic we, input logic [4:0] dest,
                                       input logic [31:0] addr, input logic mfc0, input logic ex);
        logic [92:0] b;
        b        = '0;
        b[31:0]  = 32'hBFC0_0000 | {25'd0, dest, 2'b00};
        b[63:32] = addr;
        b[68:64] = dest;
        b[69]    = we;
        b[70]    = rfm;
        b[77:71] = op;
        b[78]    = mfc0;
        b[81]    = ex;
        b[92]    = req;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        es_cancel_req = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        ws_ex = 1'b0; eret_flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   96'(ms_to_ws_valid), 96'd0);
        chk("rst_fwd",     96'(ms_fwd_blk_bus), 96'd0);
        chk("rst_bus",     96'(ms_to_ws_bus),   96'd0);
        chk("rst_allowin", 96'(ms_allowin),     96'd1);
        chk("rst_flags",   96'({ms_ex_o, ms_inst_mfc0_o}), 96'd0);
        resetn = 1'b1;

        // lw with data_ok three cycles after entry
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LW, 1, 5'd3, 32'h1000_0000, 0, 0);
        cyc(); es_to_ms_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #3;
            chk("lw_wait_valid", 96'(ms_to_ws_valid),     96'd0);
            chk("lw_pending",    96'(ms_fwd_blk_bus[41]), 96'd1);
            cyc();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344;
        #3;
        chk("lw_valid",   96'(ms_to_ws_valid),         96'd1);
        chk("lw_result",  96'(ms_to_ws_bus[63:32]),    96'h1122_3344);
        chk("lw_strb",    96'(ms_to_ws_bus[72:69]),    96'hF);
        chk("lw_pc",      96'(ms_to_ws_bus[31:0]),     96'hBFC0_000C);
        chk("lw_fwd",     96'(ms_fwd_blk_bus[41:32]),  96'({1'b0, 4'hF, 5'd3}));
        cyc(); data_sram_data_ok = 1'b0;
        #3;
        chk("lw_drained", 96'(ms_to_ws_valid), 96'd0);

        // lb then lbu at byte 3, each answered in its first MEM cycle
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LB, 1, 5'd4, 32'h0000_1003, 0, 0);
        cyc(); es_to_ms_bus = mk(1, 1, OP_LBU, 1, 5'd5, 32'h0000_1003, 0, 0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF00;
        #3;
        chk("lb_valid",   96'(ms_to_ws_valid),      96'd1);
        chk("lb_result",  96'(ms_to_ws_bus[63:32]), 96'hFFFF_FF80);
        chk("lb_allowin", 96'(ms_allowin),          96'd1);
        cyc(); es_to_ms_valid = 1'b0;
        #3;
        chk("lbu_valid",  96'(ms_to_ws_valid),       96'd1);
        chk("lbu_result", 96'(ms_to_ws_bus[63:32]),  96'h0000_0080);
        chk("lbu_dest",   96'(ms_fwd_blk_bus[36:32]), 96'd5);
        cyc(); data_sram_data_ok = 1'b0;
        #3;
        chk("lbu_drained", 96'(ms_to_ws_valid), 96'd0);

        // lwl at offset 1, lwr at offset 2
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LWL, 1, 5'd6, 32'h0000_2001, 0, 0);
        cyc(); es_to_ms_bus = mk(1, 1, OP_LWR, 1, 5'd7, 32'h0000_2002, 0, 0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD;
        #3;
        chk("lwl_result", 96'(ms_to_ws_bus[63:32]),   96'hCCDD_0000);
        chk("lwl_strb",   96'(ms_to_ws_bus[72:69]),   96'b1100);
        chk("lwl_fwd_vld", 96'(ms_fwd_blk_bus[40:37]), 96'b1100);
        cyc(); es_to_ms_valid = 1'b0;
        #3;
        chk("lwr_result", 96'(ms_to_ws_bus[63:32]), 96'h0000_AABB);
        chk("lwr_strb",   96'(ms_to_ws_bus[72:69]), 96'b0011);
        cyc(); data_sram_data_ok = 1'b0;

        // WB stall: returned data must be held in the buffer
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LW, 1, 5'd8, 32'h0000_3000, 0, 0);
        ws_allowin = 1'b0;
        cyc(); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0005;
        #3;
        chk("stall_first_valid", 96'(ms_to_ws_valid), 96'd1);
        chk("stall_first_res",   96'(ms_to_ws_bus[63:32]), 96'h5);
        chk("stall_allowin",     96'(ms_allowin),     96'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
            #3;
            chk("stall_hold_valid", 96'(ms_to_ws_valid),       96'd1);
            chk("stall_hold_res",   96'(ms_to_ws_bus[63:32]),  96'h5);
            chk("stall_hold_pend",  96'(ms_fwd_blk_bus[41]),   96'd0);
        end
        cyc(); ws_allowin = 1'b1;
        #3;
        chk("stall_release_res",   96'(ms_to_ws_bus[63:32]), 96'h5);
        chk("stall_release_allow", 96'(ms_allowin),          96'd1);
        cyc();
        #3;
        chk("stall_drained", 96'(ms_to_ws_valid), 96'd0);

        // mfc0 without a request, then an excepted load without a request
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(0, 0, OP_NONE, 1, 5'd9, 32'h1234_5678, 1, 0);
        cyc(); es_to_ms_bus = mk(0, 1, OP_LW, 1, 5'd10, 32'h0000_4000, 0, 1);
        #3;
        chk("mfc0_valid",  96'(ms_to_ws_valid),       96'd1);
        chk("mfc0_flag",   96'({ms_inst_mfc0_o, ms_ex_o}), 96'b10);
        chk("mfc0_result", 96'(ms_to_ws_bus[63:32]),  96'h1234_5678);
        chk("mfc0_strb",   96'(ms_to_ws_bus[72:69]),  96'hF);
        cyc(); es_to_ms_valid = 1'b0;
        #3;
        chk("exld_valid",  96'(ms_to_ws_valid),         96'd1);
        chk("exld_flag",   96'({ms_inst_mfc0_o, ms_ex_o}), 96'b01);
        chk("exld_strb",   96'(ms_to_ws_bus[72:69]),    96'h0);
        chk("exld_fwd",    96'(ms_fwd_blk_bus[41:37]),  96'h0);
        cyc();

        // ws_ex in WAIT together with es_cancel_req: two responses to discard
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LW, 1, 5'd11, 32'h0000_5000, 0, 0);
        cyc(); es_to_ms_valid = 1'b0; ws_ex = 1'b1; es_cancel_req = 1'b1;
        #3;
        chk("flush_valid", 96'(ms_to_ws_valid), 96'd0);
        cyc(); ws_ex = 1'b0; es_cancel_req = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LW, 1, 5'd12, 32'h0000_6000, 0, 0);
        #3;
        chk("cancel_cnt_two", 96'(dut.r_cancel_cnt), 96'd2);
        chk("flush_allowin",  96'(ms_allowin),       96'd1);
        cyc(); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_BAD1;
        #3;
        chk("drop1_valid", 96'(ms_to_ws_valid),     96'd0);
        chk("drop1_pend",  96'(ms_fwd_blk_bus[41]), 96'd1);
        cyc(); data_sram_rdata = 32'h0000_BAD2;
        #3;
        chk("drop2_valid", 96'(ms_to_ws_valid),     96'd0);
        chk("drop2_pend",  96'(ms_fwd_blk_bus[41]), 96'd1);
        cyc(); data_sram_rdata = 32'hCAFE_F00D;
        #3;
        chk("keep_valid",  96'(ms_to_ws_valid),        96'd1);
        chk("keep_result", 96'(ms_to_ws_bus[63:32]),   96'hCAFE_F00D);
        chk("keep_dest",   96'(ms_to_ws_bus[68:64]),   96'd12);
        cyc(); data_sram_data_ok = 1'b0;
        #3;
        chk("cancel_cnt_zero", 96'(dut.r_cancel_cnt), 96'd0);

        // eret flush leaves one owed response, then async reset mid-WAIT
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LW, 1, 5'd13, 32'h0000_7000, 0, 0);
        cyc(); es_to_ms_valid = 1'b0; eret_flush = 1'b1;
        #3;
        chk("eret_valid", 96'(ms_to_ws_valid), 96'd0);
        cyc(); eret_flush = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, OP_LW, 1, 5'd14, 32'h0000_8000, 0, 0);
        #3;
        chk("eret_cnt_one", 96'(dut.r_cancel_cnt), 96'd1);
        cyc(); es_to_ms_valid = 1'b0;
        #3;
        chk("prerst_pend", 96'(ms_fwd_blk_bus[41]), 96'd1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_fwd",     96'(ms_fwd_blk_bus), 96'd0);
        chk("arst_bus",     96'(ms_to_ws_bus),   96'd0);
        chk("arst_valid",   96'(ms_to_ws_valid), 96'd0);
        chk("arst_allowin", 96'(ms_allowin),     96'd1);
        chk("arst_cnt",     96'(dut.r_cancel_cnt), 96'd0);
        cyc(); resetn = 1'b1;

        // plain ALU op after reset still flows with one-cycle latency
        cyc(); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(0, 0, OP_NONE, 1, 5'd15, 32'h0BAD_CAFE, 0, 0);
        cyc(); es_to_ms_valid = 1'b0;
        #3;
        chk("post_rst_valid",  96'(ms_to_ws_valid),       96'd1);
        chk("post_rst_result", 96'(ms_to_ws_bus[63:32]),  96'h0BAD_CAFE);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_split.md
Name: mem_stage_split

Overview:
- Next-generation MEM stage for a split-transaction (req/addr_ok/data_ok) data bus.
- Sits between EX and WB, as the current MEM stage does. EX issues the memory request; this block waits for the matching data_ok.
- Buffers returned data while WB stalls, and extracts/aligns load data (lb/lbu/lh/lhu/lw/lwl/lwr) with per-byte write strobes.
- Drops responses that belong to instructions flushed by an exception or eret, and tells ID when a forwarded value is not yet available.

Parameters:
- DATA_WD, 32: data bus / register width; must be 32 (assertion).
- ES_TO_MS_WD, 93: EX→MS bus width. Bit 92 = ms_mem_req; 91:0 keep the existing field layout.
- MS_TO_WS_WD, 87: MS→WS bus width, unchanged layout.
- MAX_CANCEL, 3: maximum pending discarded responses. The counter width is clog2(MAX_CANCEL+1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EX output valid
- es_to_ms_bus  in  ES_TO_MS_WD  EX payload
- es_cancel_req  in  1  pulse: an EX-stage request already accepted by the bus was flushed
- ms_to_ws_valid  out  1  MEM output valid
- ms_to_ws_bus  out  MS_TO_WS_WD  MEM payload
- data_sram_data_ok  in  1  read/write response returned
- data_sram_rdata  in  DATA_WD  response data
- ms_fwd_blk_bus  out  42  {ms_data_pending[41], fwd_valid[40:37], dest[36:32], data[31:0]}
- ms_inst_mfc0_o  out  1  valid mfc0 in MEM
- ms_ex_o  out  1  valid exception in MEM
- ws_ex  in  1  exception flush from WB
- eret_flush  in  1  eret flush from WB

Behaviour:
- Reset (asynchronous, resetn=0) clears:
  - ms_valid, state, buf_valid, cancel_cnt, payload register.
  - All outputs derived from them, so every valid/flag output is 0 and ms_fwd_blk_bus is 0.
- flush = ws_ex | eret_flush.
- Per-instruction state:
  - WAIT: ms_mem_req=1, data not yet received.
  - DONE: data received, or no request was made.
  - Entry state is WAIT if ms_mem_req, else DONE.
- Response steering:
  - A data_ok with cancel_cnt>0 is consumed by the cancel counter: cancel_cnt decrements, data is dropped, state is unchanged.
  - Otherwise a data_ok in WAIT latches rdata into buf (buf_valid=1) and moves to DONE.
- ms_ready_go = DONE. A data_ok in the current cycle counts (bypass: load result comes from rdata that cycle, from buf afterwards).
- Handshake:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
  - Payload is loaded when es_to_ms_valid & ms_allowin.
- Flush cycle:
  - ms_valid is cleared.
  - If MEM was valid in WAIT with no data_ok that cycle, cancel_cnt += 1.
  - es_cancel_req also adds 1. Both can happen in the same cycle: +2.
  - A data_ok consumed that same cycle subtracts 1, giving a net ±.
  - A new instruction arriving during flush is dropped (ms_valid <= 0).
- cancel_cnt saturation: exceeding MAX_CANCEL is a protocol error, flagged by a simulation assertion; the counter saturates.
- A data_ok arriving with ms_valid=0 and cancel_cnt=0 is ignored and flagged by an assertion.
- Load extraction and gr_strb follow the existing rules:
  - lwl strobes: 1000/1100/1110/1111 by addr[1:0].
  - lwr strobes: 1111/0111/0011/0001.
  - Non-load: {4{gr_we}}.
  - Loads with an exception in MEM write nothing (strb=0).
- Forwarding:
  - fwd_valid = {4{ms_valid}} & gr_strb.
  - ms_data_pending = ms_valid & res_from_mem & !ms_ready_go. ID must block rather than take the data while this is set.
- ms_ex_o = ms_valid & ms_ex.
- ms_inst_mfc0_o = ms_valid & mfc0.
- All registers update on posedge clk. Latency is one cycle for a non-memory instruction, or 1+N cycles where N is the data_ok delay.

Decomposition:
- Shared package (mycpu.h): ES_TO_MS_BUS_WD=93, MS_TO_WS_BUS_WD=87, MS_FWD_BLK_BUS_WD=42, the bus field offsets, and localparams WAIT/DONE.
- One sub-module, load_align: purely combinational. Takes (addr[1:0], word, inst one-hots, gr_we) and returns (result, strb). It is reused later by a cached load path.

Test Plan:
- lw at addr 0x...0, data_ok 3 cycles later with rdata=0x11223344, ws_allowin=1 → ms_to_ws_valid in cycle 4 only, result 0x11223344, strb 1111; ms_data_pending=1 for cycles 1–3.
- lb at addr 0x3, rdata=0x80FF_FF00, data_ok same cycle as entry → result 0xFFFFFF80, 1-cycle latency. lbu at the same addr → 0x00000080.
- lwl at addr[1:0]=01 with rdata=0xAABBCCDD → result 0xCCDD0000, strb 1100. lwr at addr 10 → 0x0000AABB, strb 0011.
- data_ok with rdata=0x5 while ws_allowin=0 for 4 cycles → buf holds 0x5, output stays valid and stable, and it transfers when ws_allowin rises.
- ws_ex while MEM is in WAIT, plus es_cancel_req in the same cycle → cancel_cnt=2. The next two data_ok are dropped; the third completes the following load with its data.
- resetn deasserted asynchronously mid-WAIT with cancel_cnt=1 → all outputs 0 immediately. After release, the first data_ok is ignored (assertion fires in the negative test).
